// File: rtl/axis_fifo_pkt.sv
// -----------------------------------------------------------------------------
// axis_fifo_pkt
// AXI4-Stream FIFO carrying TDATA, TLAST (end of line) and TUSER (start of
// frame) through an inferred RAM of DEPTH-1 entries plus one output register,
// giving a total capacity of DEPTH = 2^ADDR_WIDTH words. PACKET_MODE selects
// cut-through (0) or store-and-forward (1) release of the output word.
//
// Ports
//   clk, rstn                 single clock, asynchronous active-low reset
//   s_axis_t{valid,ready}     slave handshake (ready low while full)
//   s_axis_t{data,last,user}  slave payload
//   m_axis_t{valid,ready}     master handshake
//   m_axis_t{data,last,user}  master payload, held stable under backpressure
//   level                     words held (RAM + output register), 0..DEPTH
//   pkt_count                 TLAST words held and not yet sent
// -----------------------------------------------------------------------------
module axis_fifo_pkt #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned PACKET_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned RAM_DEPTH = DEPTH - 1;
  localparam int unsigned LW        = ADDR_WIDTH + 1;
  localparam int unsigned EW        = DATA_WIDTH + 2;

  // Storage: entry layout is {tuser, tlast, tdata}
  logic [EW-1:0]         r_ram [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tlast;
  logic                  r_m_tuser;
  logic [LW-1:0]         r_level;
  logic [LW-1:0]         r_pkt_count;
  logic                  r_force_rel;
  logic                  r_pkt_seen;
  logic                  r_rdy_en;

  logic                  w_full;
  logic                  w_ram_empty;
  logic                  w_release;
  logic                  w_s_xfer;
  logic                  w_m_xfer;
  logic                  w_load;
  logic                  w_pkt_inc;
  logic                  w_pkt_dec;

  // RAM pointers run 0..DEPTH-2 and then wrap
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    if (p == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
      return '0;
    end
    return p + ADDR_WIDTH'(1);
  endfunction

  // Handshake and control decode, all from registered state
  always_comb begin
    w_full      = (r_level == LW'(DEPTH));
    w_ram_empty = ((r_level - LW'(r_out_valid)) == '0);
    // Release in packet mode waits one cycle after pkt_count leaves zero but
    // drops immediately with it; pkt_count only falls on a TLAST transfer,
    // so a presented word is never withdrawn.
    w_release   = (PACKET_MODE == 0) || ((r_pkt_count != '0) && r_pkt_seen) || r_force_rel;
    w_s_xfer    = s_axis_tvalid && r_rdy_en && !w_full;
    w_m_xfer    = r_out_valid && w_release && m_axis_tready;
    // Output register refills from RAM only; a word never bypasses the RAM
    w_load      = !w_ram_empty && (!r_out_valid || w_m_xfer);
    w_pkt_inc   = w_s_xfer && s_axis_tlast;
    w_pkt_dec   = w_m_xfer && r_m_tlast;
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (w_s_xfer) begin
      r_ram[r_wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  // Pointers, output register and status counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tlast   <= 1'b0;
      r_m_tuser   <= 1'b0;
      r_level     <= '0;
      r_pkt_count <= '0;
      r_force_rel <= 1'b0;
      r_pkt_seen  <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_rdy_en   <= 1'b1;
      r_pkt_seen <= (r_pkt_count != '0);

      if (w_s_xfer) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end

      if (w_load) begin
        r_rd_ptr                           <= ptr_inc(r_rd_ptr);
        {r_m_tuser, r_m_tlast, r_m_tdata}  <= r_ram[r_rd_ptr];
        r_out_valid                        <= 1'b1;
      end else if (w_m_xfer) begin
        r_out_valid <= 1'b0;
      end

      case ({w_s_xfer, w_m_xfer})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_count <= r_pkt_count + LW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - LW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase

      // Full with no complete packet would deadlock: stream it through
      if (w_pkt_dec) begin
        r_force_rel <= 1'b0;
      end else if (w_full && (r_pkt_count == '0)) begin
        r_force_rel <= 1'b1;
      end
    end
  end

  assign s_axis_tready = r_rdy_en && !w_full;
  assign m_axis_tvalid = r_out_valid && w_release;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign level         = r_level;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo_pkt
// Two instances with ADDR_WIDTH=4: u_ct (cut-through) and u_sf
// (store-and-forward). A directed vector table covers the basic cut-through
// flow; hand-written sequences cover full, packet release, oversize packets,
// simultaneous read/write, pointer wrap and mid-packet reset. A per-instance
// scoreboard checks data order, level and pkt_count every cycle.
// -----------------------------------------------------------------------------
module tb_axis_fifo_pkt;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;

  logic          s_valid0, s_ready0, s_last0, s_user0;
  logic          m_valid0, m_ready0, m_last0, m_user0;
  logic [DW-1:0] s_data0, m_data0;
  logic [LW-1:0] level0, pkt0;

  logic          s_valid1, s_ready1, s_last1, s_user1;
  logic          m_valid1, m_ready1, m_last1, m_user1;
  logic [DW-1:0] s_data1, m_data1;
  logic [LW-1:0] level1, pkt1;

  int errors = 0;
  int checks = 0;
  int n_in0 = 0, n_out0 = 0, pk0 = 0;
  int n_in1 = 0, n_out1 = 0, pk1 = 0;
  logic [DW+1:0] q0[$];
  logic [DW+1:0] q1[$];

  always #5 clk = ~clk;

  axis_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_MODE(0)) u_ct (
    .clk(clk), .rstn(rstn),
    .s_axis_tvalid(s_valid0), .s_axis_tready(s_ready0), .s_axis_tdata(s_data0),
    .s_axis_tlast(s_last0), .s_axis_tuser(s_user0),
    .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready0), .m_axis_tdata(m_data0),
    .m_axis_tlast(m_last0), .m_axis_tuser(m_user0),
    .level(level0), .pkt_count(pkt0)
  );

  axis_fifo_pkt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_MODE(1)) u_sf (
    .clk(clk), .rstn(rstn),
    .s_axis_tvalid(s_valid1), .s_axis_tready(s_ready1), .s_axis_tdata(s_data1),
    .s_axis_tlast(s_last1), .s_axis_tuser(s_user1),
    .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready1), .m_axis_tdata(m_data1),
    .m_axis_tlast(m_last1), .m_axis_tuser(m_user1),
    .level(level1), .pkt_count(pkt1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u_ct: state checked first, then this cycle's transfers applied
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rstn) begin
      chk("ct_level", 64'(level0), 64'(q0.size()));
      chk("ct_pkt_count", 64'(pkt0), 64'(pk0));
      if (m_valid0 && m_ready0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL ct_extra_word: got %0h expected none", m_data0);
        end else begin
          e = q0.pop_front();
          checks--;
          chk("ct_data", 64'({m_user0, m_last0, m_data0}), 64'(e));
          if (e[DW]) pk0--;
          n_out0++;
        end
      end
      if (s_valid0 && s_ready0) begin
        q0.push_back({s_user0, s_last0, s_data0});
        if (s_last0) pk0++;
        n_in0++;
      end
    end
  end

  // Scoreboard for u_sf
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rstn) begin
      chk("sf_level", 64'(level1), 64'(q1.size()));
      chk("sf_pkt_count", 64'(pkt1), 64'(pk1));
      if (m_valid1 && m_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sf_extra_word: got %0h expected none", m_data1);
        end else begin
          e = q1.pop_front();
          checks--;
          chk("sf_data", 64'({m_user1, m_last1, m_data1}), 64'(e));
          if (e[DW]) pk1--;
          n_out1++;
        end
      end
      if (s_valid1 && s_ready1) begin
        q1.push_back({s_user1, s_last1, s_data1});
        if (s_last1) pk1++;
        n_in1++;
      end
    end
  end

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          sl;
    logic          su;
    logic          mr;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          eu;
    logic [LW-1:0] elvl;
    logic [LW-1:0] epk;
    logic          erdy;
  } vec_t;

  function automatic vec_t mkv(input logic sv, input logic [DW-1:0] sd, input logic sl,
                               input logic su, input logic mr, input logic ev,
                               input logic [DW-1:0] ed, input logic el, input logic eu,
                               input logic [LW-1:0] elvl, input logic [LW-1:0] epk,
                               input logic erdy);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.su = su; v.mr = mr;
    v.ev = ev; v.ed = ed; v.el = el; v.eu = eu;
    v.elvl = elvl; v.epk = epk; v.erdy = erdy;
    return v;
  endfunction

  task automatic drain0();
    m_ready0 = 1'b1;
    for (int c = 0; c < 100 && n_out0 != n_in0; c++) cyc();
  endtask

  task automatic drive1(input int base);
    int idx;
    idx      = n_in1 - base;
    s_valid1 = (idx < 40);
    s_data1  = 32'h300 + DW'(idx);
    s_last1  = (idx == 39);
    s_user1  = (idx == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   base, base_o;
    logic got_full;

    // Alternating writes with tready=1: each word appears one cycle after
    // it is written, so level never exceeds 1
    tbl[0]  = mkv(1, 32'h1, 0, 1, 1,  0, 32'h0, 0, 0, 5'd1, 5'd0, 1);
    tbl[1]  = mkv(0, 32'h0, 0, 0, 1,  1, 32'h1, 0, 1, 5'd1, 5'd0, 1);
    tbl[2]  = mkv(1, 32'h2, 0, 0, 1,  0, 32'h0, 0, 0, 5'd1, 5'd0, 1);
    tbl[3]  = mkv(0, 32'h0, 0, 0, 1,  1, 32'h2, 0, 0, 5'd1, 5'd0, 1);
    tbl[4]  = mkv(1, 32'h3, 0, 0, 1,  0, 32'h0, 0, 0, 5'd1, 5'd0, 1);
    tbl[5]  = mkv(0, 32'h0, 0, 0, 1,  1, 32'h3, 0, 0, 5'd1, 5'd0, 1);
    tbl[6]  = mkv(1, 32'h4, 0, 0, 1,  0, 32'h0, 0, 0, 5'd1, 5'd0, 1);
    tbl[7]  = mkv(0, 32'h0, 0, 0, 1,  1, 32'h4, 0, 0, 5'd1, 5'd0, 1);
    tbl[8]  = mkv(1, 32'h5, 1, 0, 1,  0, 32'h0, 0, 0, 5'd1, 5'd1, 1);
    tbl[9]  = mkv(0, 32'h0, 0, 0, 1,  1, 32'h5, 1, 0, 5'd1, 5'd1, 1);
    tbl[10] = mkv(0, 32'h0, 0, 0, 1,  0, 32'h0, 0, 0, 5'd0, 5'd0, 1);

    rstn = 1'b1;
    s_valid0 = 0; s_data0 = '0; s_last0 = 0; s_user0 = 0; m_ready0 = 0;
    s_valid1 = 0; s_data1 = '0; s_last1 = 0; s_user1 = 0; m_ready1 = 0;
    #2 rstn = 1'b0;
    #20;
    chk("rst_ct_m_valid", 64'(m_valid0), 0);
    chk("rst_ct_s_ready", 64'(s_ready0), 0);
    chk("rst_ct_level",   64'(level0),   0);
    chk("rst_ct_pkt",     64'(pkt0),     0);
    chk("rst_ct_m_data",  64'(m_data0),  0);
    chk("rst_sf_m_valid", 64'(m_valid1), 0);
    chk("rst_sf_s_ready", 64'(s_ready1), 0);
    @(posedge clk); #3 rstn = 1'b1;
    #1 chk("rel_s_ready_low", 64'(s_ready0), 0);
    cyc();
    chk("rel_ct_s_ready", 64'(s_ready0), 1);
    chk("rel_sf_s_ready", 64'(s_ready1), 1);

    // Vector table on the cut-through instance
    for (int i = 0; i < 11; i++) begin
      s_valid0 = tbl[i].sv; s_data0 = tbl[i].sd; s_last0 = tbl[i].sl;
      s_user0  = tbl[i].su; m_ready0 = tbl[i].mr;
      cyc();
      chk($sformatf("vec%0d_m_valid", i), 64'(m_valid0), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_m_data", i), 64'(m_data0), 64'(tbl[i].ed));
        chk($sformatf("vec%0d_m_last", i), 64'(m_last0), 64'(tbl[i].el));
        chk($sformatf("vec%0d_m_user", i), 64'(m_user0), 64'(tbl[i].eu));
      end
      chk($sformatf("vec%0d_level", i), 64'(level0), 64'(tbl[i].elvl));
      chk($sformatf("vec%0d_pkt", i), 64'(pkt0), 64'(tbl[i].epk));
      chk($sformatf("vec%0d_s_ready", i), 64'(s_ready0), 64'(tbl[i].erdy));
    end
    s_valid0 = 0; s_last0 = 0; s_user0 = 0;

    // Full: 20 offered words, no reads
    m_ready0 = 0; base = n_in0; base_o = n_out0;
    for (int c = 0; c < 20; c++) begin
      s_valid0 = 1;
      s_data0  = 32'h100 + DW'(n_in0 - base);
      s_user0  = (n_in0 == base);
      s_last0  = (n_in0 - base == 15);
      cyc();
    end
    s_valid0 = 0; s_last0 = 0; s_user0 = 0;
    chk("full_accepted", 64'(n_in0 - base), 16);
    chk("full_level", 64'(level0), 64'(DEPTH));
    chk("full_s_ready", 64'(s_ready0), 0);
    m_ready0 = 1;
    cyc();
    chk("full_ready_back", 64'(s_ready0), 1);
    chk("full_level_15", 64'(level0), 15);
    drain0();
    chk("full_drained", 64'(n_out0 - base_o), 16);
    chk("full_empty_valid", 64'(m_valid0), 0);

    // Store-and-forward: 7 words, 3-cycle gap, TLAST word
    m_ready1 = 1; base_o = n_out1;
    for (int i = 0; i < 7; i++) begin
      s_valid1 = 1; s_data1 = 32'h200 + DW'(i); s_user1 = (i == 0); s_last1 = 0;
      cyc();
      chk("sf_hold_wr", 64'(m_valid1), 0);
    end
    s_valid1 = 0; s_user1 = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sf_hold_gap", 64'(m_valid1), 0);
    end
    s_valid1 = 1; s_data1 = 32'h207; s_last1 = 1;
    cyc();
    chk("sf_tlast_edge_valid", 64'(m_valid1), 0);
    chk("sf_tlast_edge_pkt", 64'(pkt1), 1);
    s_valid1 = 0; s_last1 = 0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sf_burst%0d_valid", k), 64'(m_valid1), 1);
      cyc();
    end
    chk("sf_after_valid", 64'(m_valid1), 0);
    chk("sf_after_level", 64'(level1), 0);
    chk("sf_after_count", 64'(n_out1 - base_o), 8);

    // Oversize 40-word packet in store-and-forward mode
    base = n_in1; base_o = n_out1; got_full = 0;
    for (int c = 0; c < 60 && !got_full; c++) begin
      drive1(base);
      cyc();
      if (level1 == LW'(DEPTH)) got_full = 1;
    end
    chk("os_reached_full", 64'(got_full), 1);
    chk("os_full_valid", 64'(m_valid1), 0);
    chk("os_full_ready", 64'(s_ready1), 0);
    drive1(base);
    cyc();
    chk("os_force_valid", 64'(m_valid1), 1);
    chk("os_force_pkt", 64'(pkt1), 0);
    for (int c = 0; c < 300 && (n_out1 - base_o) < 40; c++) begin
      drive1(base);
      cyc();
    end
    s_valid1 = 0; s_last1 = 0; s_user1 = 0;
    chk("os_delivered", 64'(n_out1 - base_o), 40);
    chk("os_level", 64'(level1), 0);

    // Simultaneous read/write at level 1
    m_ready0 = 0;
    s_valid0 = 1; s_data0 = 32'h400; cyc();
    s_valid0 = 0; cyc();
    chk("rw1_pre_level", 64'(level0), 1);
    chk("rw1_pre_valid", 64'(m_valid0), 1);
    s_valid0 = 1; s_data0 = 32'h401; m_ready0 = 1; cyc();
    chk("rw1_level", 64'(level0), 1);
    s_valid0 = 0;
    drain0();
    chk("rw1_drained", 64'(level0), 0);

    // Simultaneous read/write at level DEPTH-1
    m_ready0 = 0;
    for (int i = 0; i < 15; i++) begin
      s_valid0 = 1; s_data0 = 32'h500 + DW'(i); cyc();
    end
    s_valid0 = 0; cyc();
    chk("rw15_pre_level", 64'(level0), 15);
    s_valid0 = 1; s_data0 = 32'h50f; m_ready0 = 1; cyc();
    chk("rw15_level", 64'(level0), 15);
    s_valid0 = 0;
    drain0();
    chk("rw15_drained", 64'(level0), 0);

    // Random traffic covering several pointer laps
    base = n_in0;
    for (int c = 0; c < 300; c++) begin
      s_valid0 = ($urandom_range(3) != 0);
      s_data0  = DW'($urandom);
      s_last0  = ($urandom_range(7) == 0);
      s_user0  = 1'($urandom_range(1));
      m_ready0 = ($urandom_range(2) != 0);
      cyc();
    end
    s_valid0 = 0; s_last0 = 0; s_user0 = 0;
    drain0();
    chk("wrap_laps", 64'((n_in0 - base) >= 3 * 15), 1);
    chk("wrap_all_out", 64'(n_out0), 64'(n_in0));
    chk("wrap_pkt", 64'(pkt0), 0);

    // Reset mid-packet
    m_ready0 = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid0 = 1; s_data0 = 32'h600 + DW'(i); s_user0 = (i == 0); s_last0 = (i == 0);
      cyc();
    end
    s_valid0 = 0; s_user0 = 0; s_last0 = 0;
    chk("mid_pre_valid", 64'(m_valid0), 1);
    chk("mid_pre_pkt", 64'(pkt0), 1);
    #2 rstn = 1'b0;
    q0.delete(); q1.delete(); pk0 = 0; pk1 = 0;
    n_out0 = n_in0; n_out1 = n_in1;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid0), 0);
    chk("mid_rst_m_data",  64'(m_data0),  0);
    chk("mid_rst_m_last",  64'(m_last0),  0);
    chk("mid_rst_m_user",  64'(m_user0),  0);
    chk("mid_rst_level",   64'(level0),   0);
    chk("mid_rst_pkt",     64'(pkt0),     0);
    chk("mid_rst_s_ready", 64'(s_ready0), 0);
    @(posedge clk); #3 rstn = 1'b1;
    #1 chk("mid_rel_s_ready_low", 64'(s_ready0), 0);
    cyc();
    chk("mid_rel_s_ready", 64'(s_ready0), 1);
    base_o = n_out0; m_ready0 = 1;
    for (int i = 0; i < 4; i++) begin
      s_valid0 = 1; s_data0 = 32'h700 + DW'(i); s_user0 = (i == 0); s_last0 = (i == 3);
      cyc();
    end
    s_valid0 = 0; s_user0 = 0; s_last0 = 0;
    drain0();
    chk("mid_new_count", 64'(n_out0 - base_o), 4);
    chk("mid_new_level", 64'(level0), 0);
    chk("mid_new_pkt", 64'(pkt0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
